// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary stream generator and related stochastic sources.
package unary_pkg;

    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic {
        UG_THERM = 1'b0,
        UG_DIST  = 1'b1
    } ug_mode_t;

    typedef enum logic {
        UG_IDLE   = 1'b0,
        UG_STREAM = 1'b1
    } ug_state_t;

endpackage

// File: rtl/unary_dist_accum.sv
// Bresenham-style accumulator: spreads `value` ones evenly over INPUT_WIDTH steps.
module unary_dist_accum
    import unary_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic [COUNT_WIDTH-1:0] value,
    output logic                   dist_bit_c,
    output logic [COUNT_WIDTH-1:0] acc
);

    localparam int unsigned SUM_WIDTH = COUNT_WIDTH + 1;

    logic [SUM_WIDTH-1:0]   sum_c;
    logic [COUNT_WIDTH-1:0] acc_q;
    logic [COUNT_WIDTH-1:0] acc_d;

    // acc < INPUT_WIDTH and value <= INPUT_WIDTH, so one extra bit holds the sum.
    always_comb begin
        sum_c      = SUM_WIDTH'(acc_q) + SUM_WIDTH'(value);
        dist_bit_c = (sum_c >= SUM_WIDTH'(INPUT_WIDTH));
        acc_d      = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            if (dist_bit_c) begin
                acc_d = COUNT_WIDTH'(sum_c - SUM_WIDTH'(INPUT_WIDTH));
            end else begin
                acc_d = COUNT_WIDTH'(sum_c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/unary_stream_gen.sv
// Binary-to-unary stream generator: emits INPUT_WIDTH bits holding exactly in_value ones.
module unary_stream_gen
    import unary_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_value,
    input  logic                   mode,
    input  logic                   hold,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   last,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] sent_count
);

    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(INPUT_WIDTH - 1);

    ug_state_t              state_q, state_d;
    ug_mode_t               mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] value_q, value_d;
    logic [COUNT_WIDTH-1:0] sent_count_q, sent_count_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;

    logic                   acc_en_c;
    logic                   acc_clr_c;
    logic                   dist_bit_c;
    logic                   therm_bit_c;
    logic [COUNT_WIDTH-1:0] sat_value_c;
    logic [COUNT_WIDTH-1:0] acc_unused;

    unary_dist_accum #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .en         (acc_en_c),
        .clr        (acc_clr_c),
        .value      (value_q),
        .dist_bit_c (dist_bit_c),
        .acc        (acc_unused)
    );

    assign in_ready    = (state_q == UG_IDLE) & reset;
    assign therm_bit_c = (sent_count_q < value_q);
    assign sat_value_c = (in_value > FULL_COUNT) ? FULL_COUNT : in_value;

    // Next-state and registered-output logic; a bit is issued only on an unheld STREAM edge.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        value_d      = value_q;
        sent_count_d = sent_count_q;
        bit_out_d    = 1'b0;
        bit_valid_d  = 1'b0;
        last_d       = 1'b0;
        busy_d       = busy_q;
        acc_en_c     = 1'b0;
        acc_clr_c    = 1'b0;

        case (state_q)
            UG_IDLE: begin
                if (in_valid) begin
                    state_d      = UG_STREAM;
                    mode_d       = ug_mode_t'(mode);
                    value_d      = sat_value_c;
                    sent_count_d = '0;
                    busy_d       = 1'b1;
                    acc_clr_c    = 1'b1;
                end
            end
            UG_STREAM: begin
                if (!hold) begin
                    bit_valid_d  = 1'b1;
                    bit_out_d    = (mode_q == UG_DIST) ? dist_bit_c : therm_bit_c;
                    sent_count_d = sent_count_q + COUNT_WIDTH'(1);
                    acc_en_c     = (mode_q == UG_DIST);
                    if (sent_count_q == LAST_INDEX) begin
                        last_d  = 1'b1;
                        state_d = UG_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = UG_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= UG_IDLE;
            mode_q       <= UG_THERM;
            value_q      <= '0;
            sent_count_q <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            value_q      <= value_d;
            sent_count_q <= sent_count_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign sent_count = sent_count_q;

endmodule
